// File: rtl/bp_nonsynth_mem_latency_shim_if.sv
`default_nettype none
// ============================================================================
// Module      : bp_nonsynth_mem_latency_shim_if
// Description : Valid/ready message channel into the latency shim and
//               valid/yumi channel out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_nonsynth_mem_latency_shim_if #(
  parameter int width_p = 1,
  parameter int els_p   = 16
);
  logic [width_p-1:0]         data_i;
  logic                       v_i;
  logic                       ready_o;
  logic [width_p-1:0]         data_o;
  logic                       v_o;
  logic                       yumi_i;
  logic [$clog2(els_p+1)-1:0] count_o;

  // master: the testbench/client side; slave: the shim itself
  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, v_o, count_o
  );
  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, v_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_nonsynth_mem_latency_shim.sv
`default_nettype none
// ============================================================================
// Module      : bp_nonsynth_mem_latency_shim
// Description : In-order latency-injection buffer; each message is held until
//               its release time (fixed, fixed+LFSR jitter, or minimal).
// Revision    : 1.0 - initial release
// ============================================================================
module bp_nonsynth_mem_latency_shim #(
  parameter int          width_p         = 1,
  parameter int          els_p           = 16,
  parameter int          mode_p          = 0,
  parameter int          fixed_latency_p = 100,
  parameter int          jitter_width_p  = 4,
  parameter logic [15:0] seed_p          = 16'hACE1,
  parameter int          cycle_width_p   = 32
) (
  input wire logic                    clk_i,
  input wire logic                    reset_i,
  bp_nonsynth_mem_latency_shim_if.slave link
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_cnt_w = $clog2(els_p + 1);
  localparam int c_cw    = cycle_width_p;

  logic [width_p-1:0] r_data_mem [els_p];
  logic [c_cw-1:0]    r_rel_mem  [els_p];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cw-1:0]    r_now;
  logic [c_cw-1:0]    r_last_release;
  logic [15:0]        r_lfsr;

  logic               w_full;
  logic               w_empty;
  logic [c_cw-1:0]    w_head_diff;
  logic               w_head_ready;
  logic               w_enq;
  logic               w_deq;
  logic [c_cnt_w-1:0] w_count_after_deq;
  logic [c_cw-1:0]    w_latency;
  logic [c_cw-1:0]    w_cand;
  logic [c_cw-1:0]    w_cand_diff;
  logic [c_cw-1:0]    w_release;
  logic               w_lfsr_fb;

  generate
    if (mode_p == 1) begin : g_jitter
      assign w_latency = c_cw'(fixed_latency_p) + c_cw'(r_lfsr[jitter_width_p-1:0]);
    end else if (mode_p == 2) begin : g_minimal
      assign w_latency = c_cw'(1);
    end else begin : g_fixed
      assign w_latency = c_cw'(fixed_latency_p);
    end
  endgenerate

  assign w_full            = (r_count == c_cnt_w'(els_p));
  assign w_empty           = (r_count == '0);
  // Signed-difference compares keep release checks correct across wrap of now
  assign w_head_diff       = r_now - r_rel_mem[r_rptr];
  assign w_head_ready      = ~w_empty & ~w_head_diff[c_cw-1];
  assign w_enq             = link.v_i & ~w_full;
  assign w_deq             = link.yumi_i & w_head_ready;
  assign w_count_after_deq = r_count - c_cnt_w'(w_deq);
  assign w_cand            = r_now + w_latency;
  assign w_cand_diff       = w_cand - r_last_release;
  // Clamping to the previous release keeps release times monotonic, so order holds
  assign w_release         = ((w_count_after_deq != '0) && w_cand_diff[c_cw-1])
                             ? r_last_release : w_cand;
  assign w_lfsr_fb         = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_now          <= '0;
      r_lfsr         <= seed_p;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_last_release <= '0;
    end else begin
      r_now   <= r_now + c_cw'(1);
      r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
      if (w_enq) begin
        r_wptr         <= r_wptr + c_ptr_w'(1);
        r_last_release <= w_release;
        r_lfsr         <= {w_lfsr_fb, r_lfsr[15:1]};
      end
      if (w_deq) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_data_mem[r_wptr] <= link.data_i;
      r_rel_mem[r_wptr]  <= w_release;
    end
  end

  assign link.ready_o = ~w_full;
  assign link.v_o     = w_head_ready;
  assign link.data_o  = r_data_mem[r_rptr];
  assign link.count_o = r_count;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    link.yumi_i |-> link.v_o);
  a_data_held_while_stalled: assert property (@(posedge clk_i) disable iff (reset_i)
    (link.v_i && !link.ready_o) |=> (!link.v_i || $stable(link.data_i)));

endmodule
`default_nettype wire
